// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: block-transfer port between a cache-side requester and a
// physical-memory-side responder.
//   read    : block read request, held until resp
//   write   : block write request, held until resp
//   address : 16-bit byte address; the low nibble selects nothing
//   wdata   : 128-bit write block
//   rdata   : 128-bit read block
//   resp    : one-cycle completion pulse
// modport master: the side that issues requests (a cache, or the arbiter
//                 toward physical memory).
// modport slave : the side that answers them.
interface mem_arbiter_if;
    logic         read;
    logic         write;
    logic [15:0]  address;
    logic [127:0] wdata;
    logic [127:0] rdata;
    logic         resp;

    modport master (
        output read, write, address, wdata,
        input  rdata, resp
    );

    modport slave (
        input  read, write, address, wdata,
        output rdata, resp
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one physical memory port between the I-cache and the
// D-cache miss ports of the pipelined LC-3b.
//
// Ports:
//   clk      : system clock, all state changes on the rising edge
//   reset    : synchronous, active-high
//   i_port   : I-cache miss port (slave; read only, write/wdata ignored)
//   d_port   : D-cache miss port (slave; read and write-back)
//   mem_port : physical memory port (master); read/write/address/wdata are
//              registered, address is block aligned
//
// Build option MEM_ARB_WB_BUFFER_EN:
//   defined   - one-entry write-back buffer. A dirty eviction is acked at
//               once and drained to memory later (DRAIN), reads of the
//               buffered block are answered from the buffer.
//               IDLE priority: D fwd > D write > D read > I fwd > I read > drain.
//   undefined - write-backs go straight to memory through D_WRITE.
//               IDLE priority: D write > D read > I read.
//
// Cache responses are combinational: a memory resp is passed to the
// requester in the same cycle, and buffer hits are acked in the request cycle.
module mem_arbiter (
    input  logic          clk,
    input  logic          reset,
    mem_arbiter_if.slave  i_port,
    mem_arbiter_if.slave  d_port,
    mem_arbiter_if.master mem_port
);

    typedef enum logic [2:0] {
        IDLE,
        D_READ,
        I_READ,
        DRAIN,
        D_WRITE
    } state_t;

    state_t       state_reg;
    logic         pmem_read_reg;
    logic         pmem_write_reg;
    logic [15:0]  pmem_address_reg;
    logic [127:0] pmem_wdata_reg;

    logic         i_resp;
    logic         d_resp;
    logic [127:0] i_rdata;
    logic [127:0] d_rdata;

    logic [11:0]  i_tag;
    logic [11:0]  d_tag;

    assign i_tag = i_port.address[15:4];
    assign d_tag = d_port.address[15:4];

    // The I-cache never writes and byte offsets never matter.
    logic unused_bits;
    assign unused_bits = ^{i_port.write, i_port.wdata,
                           i_port.address[3:0], d_port.address[3:0]};

`ifdef MEM_ARB_WB_BUFFER_EN
    logic         wb_valid_reg;
    logic [11:0]  wb_tag_reg;
    logic [127:0] wb_data_reg;
    logic         d_fwd;
    logic         i_fwd;

    assign d_fwd = d_port.read && wb_valid_reg && (d_tag == wb_tag_reg);
    assign i_fwd = i_port.read && wb_valid_reg && (i_tag == wb_tag_reg);
`endif

    // Response routing. Outside the forwarding cases both caches just see
    // the memory read bus; only the addressed one gets a resp pulse.
    always_comb begin
        i_resp  = 1'b0;
        d_resp  = 1'b0;
        i_rdata = mem_port.rdata;
        d_rdata = mem_port.rdata;
        case (state_reg)
            IDLE: begin
`ifdef MEM_ARB_WB_BUFFER_EN
                if (d_fwd) begin
                    d_resp  = 1'b1;
                    d_rdata = wb_data_reg;
                end else if (d_port.write && !wb_valid_reg) begin
                    d_resp = 1'b1;
                end else if (!d_port.read && !d_port.write && i_fwd) begin
                    // An I forward only wins when the D side is silent,
                    // so the two resps can never coincide.
                    i_resp  = 1'b1;
                    i_rdata = wb_data_reg;
                end
`endif
            end
            D_READ, D_WRITE: d_resp = mem_port.resp;
            I_READ:          i_resp = mem_port.resp;
            default:         ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg        <= IDLE;
            pmem_read_reg    <= 1'b0;
            pmem_write_reg   <= 1'b0;
            pmem_address_reg <= 16'h0000;
            pmem_wdata_reg   <= '0;
`ifdef MEM_ARB_WB_BUFFER_EN
            wb_valid_reg     <= 1'b0;
            wb_tag_reg       <= 12'h000;
            wb_data_reg      <= '0;
`endif
        end else begin
            case (state_reg)
                IDLE: begin
`ifdef MEM_ARB_WB_BUFFER_EN
                    if (d_fwd) begin
                        state_reg <= IDLE;
                    end else if (d_port.write && !wb_valid_reg) begin
                        wb_valid_reg <= 1'b1;
                        wb_tag_reg   <= d_tag;
                        wb_data_reg  <= d_port.wdata;
                    end else if (d_port.write) begin
                        // Buffer occupied: drain it, the new write-back
                        // stays held and is absorbed on return to IDLE.
                        state_reg        <= DRAIN;
                        pmem_write_reg   <= 1'b1;
                        pmem_address_reg <= {wb_tag_reg, 4'b0000};
                        pmem_wdata_reg   <= wb_data_reg;
                    end else if (d_port.read) begin
                        state_reg        <= D_READ;
                        pmem_read_reg    <= 1'b1;
                        pmem_address_reg <= {d_tag, 4'b0000};
                    end else if (i_fwd) begin
                        state_reg <= IDLE;
                    end else if (i_port.read) begin
                        state_reg        <= I_READ;
                        pmem_read_reg    <= 1'b1;
                        pmem_address_reg <= {i_tag, 4'b0000};
                    end else if (wb_valid_reg) begin
                        state_reg        <= DRAIN;
                        pmem_write_reg   <= 1'b1;
                        pmem_address_reg <= {wb_tag_reg, 4'b0000};
                        pmem_wdata_reg   <= wb_data_reg;
                    end
`else
                    if (d_port.write) begin
                        state_reg        <= D_WRITE;
                        pmem_write_reg   <= 1'b1;
                        pmem_address_reg <= {d_tag, 4'b0000};
                        pmem_wdata_reg   <= d_port.wdata;
                    end else if (d_port.read) begin
                        state_reg        <= D_READ;
                        pmem_read_reg    <= 1'b1;
                        pmem_address_reg <= {d_tag, 4'b0000};
                    end else if (i_port.read) begin
                        state_reg        <= I_READ;
                        pmem_read_reg    <= 1'b1;
                        pmem_address_reg <= {i_tag, 4'b0000};
                    end
`endif
                end
                D_READ, I_READ: begin
                    if (mem_port.resp) begin
                        pmem_read_reg <= 1'b0;
                        state_reg     <= IDLE;
                    end
                end
`ifdef MEM_ARB_WB_BUFFER_EN
                DRAIN: begin
                    if (mem_port.resp) begin
                        pmem_write_reg <= 1'b0;
                        wb_valid_reg   <= 1'b0;
                        state_reg      <= IDLE;
                    end
                end
`endif
                D_WRITE: begin
                    if (mem_port.resp) begin
                        pmem_write_reg <= 1'b0;
                        state_reg      <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign mem_port.read    = pmem_read_reg;
    assign mem_port.write   = pmem_write_reg;
    assign mem_port.address = pmem_address_reg;
    assign mem_port.wdata   = pmem_wdata_reg;

    assign i_port.resp  = i_resp;
    assign i_port.rdata = i_rdata;
    assign d_port.resp  = d_resp;
    assign d_port.rdata = d_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: self-checking bench for mem_arbiter.
// Cache drivers push the expected response when they issue a request; a
// monitor pops and compares whenever a cache resp is seen. The reference is
// the view "memory behaves as one coherent store": a D read returns the last
// block written to that tag, whatever the arbiter buffers internally.
// A behavioural memory with random latency logs every access so directed
// tests can check access order.
module tb_mem_arbiter;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mem_arbiter_if i_bus ();
    mem_arbiter_if d_bus ();
    mem_arbiter_if m_bus ();

    mem_arbiter dut (
        .clk      (clk),
        .reset    (reset),
        .i_port   (i_bus),
        .d_port   (d_bus),
        .mem_port (m_bus)
    );

    typedef struct {
        bit           wr;
        logic [15:0]  addr;
        logic [127:0] data;
    } acc_t;

    int checks = 0;
    int errors = 0;

    acc_t         mem_log [$];
    logic [127:0] phys_mem [logic [11:0]];
    logic [127:0] ref_mem  [logic [11:0]];
    logic [127:0] d_exp [$];
    bit           d_exp_wr [$];
    logic [127:0] i_exp [$];
    int           mem_lat_min = 1;
    int           mem_lat_max = 4;

    function automatic logic [127:0] init_pat(input logic [11:0] t);
        return {8{t, 4'h5}};
    endfunction

    function automatic logic [127:0] ref_read(input logic [11:0] t);
        if (ref_mem.exists(t)) return ref_mem[t];
        return init_pat(t);
    endfunction

    function automatic logic [127:0] phys_read(input logic [11:0] t);
        if (phys_mem.exists(t)) return phys_mem[t];
        return init_pat(t);
    endfunction

    function automatic void chk(input string name, input logic [127:0] act,
                                input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endfunction

    function automatic void fail(input string name, input string detail);
        checks++;
        errors++;
        $display("FAIL %s: %s", name, detail);
    endfunction

    // ---------------- cache drivers ----------------
    task automatic d_op(input bit wr, input logic [15:0] addr,
                        input logic [127:0] data, output int lat);
        bit          got;
        logic [11:0] t;
        t = addr[15:4];
        if (wr) begin
            ref_mem[t] = data;
            d_exp.push_back('0);
            d_exp_wr.push_back(1'b1);
        end else begin
            d_exp.push_back(ref_read(t));
            d_exp_wr.push_back(1'b0);
        end
        d_bus.read    = !wr;
        d_bus.write   = wr;
        d_bus.address = addr;
        d_bus.wdata   = data;
        lat = 0;
        got = 1'b0;
        while (!got && lat < 400) begin
            @(negedge clk);
            lat++;
            got = d_bus.resp;
        end
        if (!got) fail("d_op_timeout", $sformatf("no d resp for addr %h", addr));
        @(posedge clk);
        #1;
        d_bus.read  = 1'b0;
        d_bus.write = 1'b0;
        $display("d_op wr=%0b addr=%h lat=%0d", wr, addr, lat);
    endtask

    task automatic i_op(input logic [15:0] addr, output int lat);
        bit got;
        i_exp.push_back(ref_read(addr[15:4]));
        i_bus.read    = 1'b1;
        i_bus.address = addr;
        lat = 0;
        got = 1'b0;
        while (!got && lat < 400) begin
            @(negedge clk);
            lat++;
            got = i_bus.resp;
        end
        if (!got) fail("i_op_timeout", $sformatf("no i resp for addr %h", addr));
        @(posedge clk);
        #1;
        i_bus.read = 1'b0;
        $display("i_op addr=%h lat=%0d", addr, lat);
    endtask

    task automatic quiesce();
        repeat (30) @(posedge clk);
        #1;
    endtask

    task automatic check_log(input string name, input acc_t exp [$]);
        chk({name, "_len"}, mem_log.size(), exp.size());
        for (int k = 0; k < exp.size() && k < mem_log.size(); k++) begin
            chk($sformatf("%s_%0d_wr", name, k), mem_log[k].wr, exp[k].wr);
            chk($sformatf("%s_%0d_addr", name, k), mem_log[k].addr, exp[k].addr);
            if (exp[k].wr)
                chk($sformatf("%s_%0d_data", name, k), mem_log[k].data, exp[k].data);
        end
    endtask

    // ---------------- scoreboard monitor ----------------
    logic [127:0] mon_exp;
    bit           mon_wr;
    always @(negedge clk) begin
        if (!reset) begin
            if (d_bus.resp && i_bus.resp)
                fail("resp_exclusive", "i and d resp in the same cycle");
            if (d_bus.resp) begin
                if (d_exp.size() == 0) begin
                    fail("d_resp_unexpected", "d resp with nothing outstanding");
                end else begin
                    mon_exp = d_exp.pop_front();
                    mon_wr  = d_exp_wr.pop_front();
                    if (!mon_wr) chk("d_rdata", d_bus.rdata, mon_exp);
                end
            end
            if (i_bus.resp) begin
                if (i_exp.size() == 0) begin
                    fail("i_resp_unexpected", "i resp with nothing outstanding");
                end else begin
                    mon_exp = i_exp.pop_front();
                    chk("i_rdata", i_bus.rdata, mon_exp);
                end
            end
            if (m_bus.resp && m_bus.read)
                chk("rd_resp_routed", d_bus.resp || i_bus.resp, 1'b1);
        end
    end

    // ---------------- physical memory model ----------------
    int   mem_cnt;
    int   mem_lat;
    bit   mem_busy;
    acc_t mem_cur;
    initial begin
        m_bus.resp  = 1'b0;
        m_bus.rdata = '0;
        mem_busy    = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (reset) begin
                m_bus.resp = 1'b0;
                mem_busy   = 1'b0;
            end else if (m_bus.resp) begin
                m_bus.resp = 1'b0;
                mem_busy   = 1'b0;
            end else if (m_bus.read || m_bus.write) begin
                if (!mem_busy) begin
                    mem_busy = 1'b1;
                    mem_cnt  = 0;
                    mem_lat  = $urandom_range(mem_lat_max, mem_lat_min);
                    mem_cur  = '{m_bus.write, m_bus.address, m_bus.wdata};
                    mem_log.push_back(mem_cur);
                    chk("pmem_addr_align", m_bus.address[3:0], 4'h0);
                end else begin
                    chk("pmem_addr_stable", m_bus.address, mem_cur.addr);
                    chk("pmem_kind_stable", m_bus.write, mem_cur.wr);
                    if (mem_cur.wr) chk("pmem_wdata_stable", m_bus.wdata, mem_cur.data);
                end
                mem_cnt++;
                if (mem_cnt >= mem_lat) begin
                    if (mem_cur.wr) phys_mem[mem_cur.addr[15:4]] = mem_cur.data;
                    else            m_bus.rdata = phys_read(mem_cur.addr[15:4]);
                    m_bus.resp = 1'b1;
                end
            end else begin
                mem_busy = 1'b0;
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not finish in time");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        int            l1, l2;
        acc_t          e [$];
        logic [127:0]  xa, xb, xc, yv, zv, old6;
        bit            saw;

        reset         = 1'b1;
        i_bus.read    = 1'b0;
        i_bus.write   = 1'b0;
        i_bus.address = 16'h0;
        i_bus.wdata   = '0;
        d_bus.read    = 1'b0;
        d_bus.write   = 1'b0;
        d_bus.address = 16'h0;
        d_bus.wdata   = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_pmem_read", m_bus.read, 1'b0);
        chk("reset_pmem_write", m_bus.write, 1'b0);
        chk("reset_pmem_addr", m_bus.address, 16'h0);
        chk("reset_pmem_wdata", m_bus.wdata, 128'h0);
        chk("reset_d_resp", d_bus.resp, 1'b0);
        chk("reset_i_resp", i_bus.resp, 1'b0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // T1: I read, one-cycle issue latency, aligned address
        phys_mem[12'h123] = {32{4'hA}};
        ref_mem[12'h123]  = {32{4'hA}};
        fork
            i_op(16'h1234, l1);
            begin
                @(negedge clk);
                chk("t1_no_read_same_cycle", m_bus.read, 1'b0);
                @(negedge clk);
                chk("t1_pmem_read", m_bus.read, 1'b1);
                chk("t1_pmem_addr", m_bus.address, 16'h1230);
            end
        join

        // T2: simultaneous I and D reads, D first
        quiesce();
        mem_log.delete();
        fork
            i_op(16'h2000, l1);
            d_op(1'b0, 16'h4000, '0, l2);
        join
        quiesce();
        e.delete();
        e.push_back('{1'b0, 16'h4000, 128'h0});
        e.push_back('{1'b0, 16'h2000, 128'h0});
        check_log("t2_order", e);

        // T3: write-back then a read of another block
        xa = {4{32'hDEAD_0001}};
        quiesce();
        mem_log.delete();
        d_op(1'b1, 16'h6010, xa, l1);
        d_op(1'b0, 16'h8000, '0, l2);
        quiesce();
        e.delete();
`ifdef MEM_ARB_WB_BUFFER_EN
        chk("t3_wb_ack_lat", l1, 1);
        e.push_back('{1'b0, 16'h8000, 128'h0});
        e.push_back('{1'b1, 16'h6010, xa});
`else
        e.push_back('{1'b1, 16'h6010, xa});
        e.push_back('{1'b0, 16'h8000, 128'h0});
`endif
        check_log("t3_order", e);

        // T4: read of the just-written block
        xb = {4{32'hBEEF_0002}};
        mem_log.delete();
        d_op(1'b1, 16'h6010, xb, l1);
        d_op(1'b0, 16'h6018, '0, l2);
        quiesce();
        e.delete();
        e.push_back('{1'b1, 16'h6010, xb});
`ifdef MEM_ARB_WB_BUFFER_EN
        chk("t4_fwd_lat", l2, 1);
`else
        e.push_back('{1'b0, 16'h6010, 128'h0});
`endif
        check_log("t4_order", e);

        // T5: second write-back while the first is still held
        xc = {4{32'hC0DE_0003}};
        yv = {4{32'h7777_0004}};
        mem_log.delete();
        d_op(1'b1, 16'h6010, xc, l1);
        d_op(1'b1, 16'h7000, yv, l2);
        quiesce();
        e.delete();
        e.push_back('{1'b1, 16'h6010, xc});
        e.push_back('{1'b1, 16'h7000, yv});
`ifdef MEM_ARB_WB_BUFFER_EN
        chk("t5_first_ack_lat", l1, 1);
        chk("t5_second_waits", (l2 > 1), 1'b1);
`endif
        check_log("t5_order", e);

        // T6: reset in the middle of a D read
        zv   = {4{32'h5A5A_0006}};
        old6 = ref_read(12'h601);
        d_op(1'b1, 16'h6010, zv, l1);
        mem_lat_min   = 60;
        mem_lat_max   = 60;
        d_bus.read    = 1'b1;
        d_bus.address = 16'h8000;
        saw = 1'b0;
        for (int k = 0; k < 10 && !saw; k++) begin
            @(negedge clk);
            saw = m_bus.read;
        end
        if (!saw) fail("t6_read_issue", "pmem_read never rose");
        @(posedge clk);
        #1;
        reset      = 1'b1;
        d_bus.read = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("t6_pmem_read", m_bus.read, 1'b0);
        chk("t6_pmem_write", m_bus.write, 1'b0);
        chk("t6_pmem_addr", m_bus.address, 16'h0);
        chk("t6_d_resp", d_bus.resp, 1'b0);
        chk("t6_i_resp", i_bus.resp, 1'b0);
        @(posedge clk);
        #1;
        reset       = 1'b0;
        mem_lat_min = 1;
        mem_lat_max = 4;
`ifdef MEM_ARB_WB_BUFFER_EN
        ref_mem[12'h601] = old6;   // buffered block is lost on reset
`endif
        mem_log.delete();
        quiesce();
        chk("t6_no_drain_after_reset", mem_log.size(), 0);
        d_op(1'b0, 16'h6010, '0, l1);

        // Random phase: D and I run concurrently on disjoint block ranges
        fork
            begin
                for (int n = 0; n < 120; n++) begin
                    logic [15:0]  a;
                    logic [127:0] dv;
                    bit           w;
                    int           g;
                    a  = {12'h400 + 12'($urandom_range(0, 7)), 4'($urandom_range(0, 15))};
                    w  = 1'($urandom_range(0, 1));
                    dv = {$urandom, $urandom, $urandom, $urandom};
                    d_op(w, a, dv, l1);
                    g = $urandom_range(1, 3);
                    repeat (g) @(posedge clk);
                    #1;
                end
            end
            begin
                for (int n = 0; n < 80; n++) begin
                    logic [15:0] a;
                    int          g;
                    int          li;
                    a = {12'h100 + 12'($urandom_range(0, 7)), 4'($urandom_range(0, 15))};
                    i_op(a, li);
                    g = $urandom_range(0, 3);
                    if (g > 0) begin
                        repeat (g) @(posedge clk);
                        #1;
                    end
                end
            end
        join

        quiesce();
        chk("d_exp_drained", d_exp.size(), 0);
        chk("i_exp_drained", i_exp.size(), 0);
        foreach (ref_mem[t])
            chk($sformatf("final_mem_%h", t), phys_read(t), ref_mem[t]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
